// File: rtl/mini_ex_core_pkg.sv
// Shared types and constants for the mini_ex_core execute stage:
// register-file write port, write-back arbiter state and source encodings.
package mini_ex_core_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_IDX_W  = $clog2(NUM_REGS);

  typedef struct packed {
    logic                  WriteEnableQ100H;
    logic [REG_IDX_W-1:0]  DstRegQ100H;
    logic [DATA_WIDTH-1:0] WriteValueQ100H;
  } t_rg_write;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } t_rf_arb_state;

  typedef enum logic {
    ALU = 1'b0,
    MEM = 1'b1
  } t_wb_src;

endpackage

// File: rtl/mini_ex_core_rf_wr_arb_if.sv
// Write-back requester handshakes plus the register-file write port they share.
interface mini_ex_core_rf_wr_arb_if #(
  parameter int DATA_WIDTH = mini_ex_core_pkg::DATA_WIDTH
);

  logic                                   AluWrValid;
  logic [mini_ex_core_pkg::REG_IDX_W-1:0] AluWrReg;
  logic [DATA_WIDTH-1:0]                  AluWrData;
  logic                                   AluWrReady;
  logic                                   MemWrValid;
  logic [mini_ex_core_pkg::REG_IDX_W-1:0] MemWrReg;
  logic [DATA_WIDTH-1:0]                  MemWrData;
  logic                                   MemWrReady;
  mini_ex_core_pkg::t_rg_write            RgWrite;
  logic                                   InitDone;

  modport master (
    output AluWrValid, AluWrReg, AluWrData,
    output MemWrValid, MemWrReg, MemWrData,
    input  AluWrReady, MemWrReady, RgWrite, InitDone
  );

  modport slave (
    input  AluWrValid, AluWrReg, AluWrData,
    input  MemWrValid, MemWrReg, MemWrData,
    output AluWrReady, MemWrReady, RgWrite, InitDone
  );

endinterface

// File: rtl/mini_ex_core_rr_arb2.sv
// Two-way round-robin grant between the ALU and MEM write-back requesters.
module mini_ex_core_rr_arb2 (
  input  logic Clock,
  input  logic Rst,
  input  logic en_i,
  input  logic alu_valid_i,
  input  logic mem_valid_i,
  output logic alu_grant_o,
  output logic mem_grant_o
);
  import mini_ex_core_pkg::*;

  t_wb_src last_grant_q;
  t_wb_src last_grant_d;

  // On a conflict, whoever did not win last time gets the port.
  assign alu_grant_o = en_i && alu_valid_i && (!mem_valid_i || last_grant_q == MEM);
  assign mem_grant_o = en_i && mem_valid_i && (!alu_valid_i || last_grant_q == ALU);

  always_comb begin
    last_grant_d = last_grant_q;
    if (alu_grant_o) begin
      last_grant_d = ALU;
    end else if (mem_grant_o) begin
      last_grant_d = MEM;
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      last_grant_q <= MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mini_ex_core_rf_wr_arb.sv
// Register-file write arbiter: zero-fills every register after reset, then
// merges ALU and MEM write-backs onto the single registered write port.
module mini_ex_core_rf_wr_arb #(
  parameter int DATA_WIDTH = mini_ex_core_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = mini_ex_core_pkg::NUM_REGS
) (
  input  logic                     Clock,
  input  logic                     Rst,
  mini_ex_core_rf_wr_arb_if.slave  bus
);
  import mini_ex_core_pkg::*;

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

  t_rf_arb_state         state_q;
  logic [REG_IDX_W-1:0]  init_cnt_q;
  logic                  init_done_q;
  t_rg_write             rg_write_q;

  logic                  alu_grant;
  logic                  mem_grant;
  logic                  wr_any_d;
  logic [REG_IDX_W-1:0]  wr_reg_d;
  logic [DATA_WIDTH-1:0] wr_value_d;

  mini_ex_core_rr_arb2 u_rr_arb2 (
    .Clock       (Clock),
    .Rst         (Rst),
    .en_i        (state_q == RUN),
    .alu_valid_i (bus.AluWrValid),
    .mem_valid_i (bus.MemWrValid),
    .alu_grant_o (alu_grant),
    .mem_grant_o (mem_grant)
  );

  assign bus.AluWrReady = alu_grant;
  assign bus.MemWrReady = mem_grant;
  assign bus.RgWrite    = rg_write_q;
  assign bus.InitDone   = init_done_q;

  always_comb begin
    wr_any_d   = alu_grant || mem_grant;
    wr_reg_d   = alu_grant ? bus.AluWrReg  : bus.MemWrReg;
    wr_value_d = alu_grant ? bus.AluWrData : bus.MemWrData;
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rg_write_q  <= '0;
    end else begin
      rg_write_q <= '0;
      case (state_q)
        INIT: begin
          rg_write_q.WriteEnableQ100H <= 1'b1;
          rg_write_q.DstRegQ100H      <= init_cnt_q;
          init_cnt_q                  <= init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_IDX) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          // Writes to r0 still complete the handshake but never reach the file.
          if (wr_any_d && (wr_reg_d != '0)) begin
            rg_write_q.WriteEnableQ100H <= 1'b1;
            rg_write_q.DstRegQ100H      <= wr_reg_d;
            rg_write_q.WriteValueQ100H  <= wr_value_d;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_ex_core_rf_wr_arb.sv
// Directed bench for the register-file write arbiter: init sweep, arbitration,
// r0 suppression, mid-run reset and requests raised during initialisation.
module tb_mini_ex_core_rf_wr_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mini_ex_core_rf_wr_arb_if #(.DATA_WIDTH(32)) bus ();

  mini_ex_core_rf_wr_arb #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .Clock (clk),
    .Rst   (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rg(input string tag, input logic we, input logic [4:0] dst,
                        input logic [31:0] val);
    chk({tag, ".we"},  64'(bus.RgWrite.WriteEnableQ100H), 64'(we));
    chk({tag, ".dst"}, 64'(bus.RgWrite.DstRegQ100H),      64'(dst));
    chk({tag, ".val"}, 64'(bus.RgWrite.WriteValueQ100H),  64'(val));
  endtask

  task automatic chk_rdy(input string tag, input logic alu, input logic mem);
    chk({tag, ".alu_rdy"}, 64'(bus.AluWrReady), 64'(alu));
    chk({tag, ".mem_rdy"}, 64'(bus.MemWrReady), 64'(mem));
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bus.AluWrValid = av; bus.AluWrReg = ar; bus.AluWrData = ad;
    bus.MemWrValid = mv; bus.MemWrReg = mr; bus.MemWrData = md;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with both requesters pending: nothing may be granted.
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    @(posedge clk);
    cycle();
    chk_rg("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.init_done", 64'(bus.InitDone), 64'd0);
    chk_rdy("reset", 1'b0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-fill: registered write port shows Dst=0..31 on consecutive cycles.
    for (int i = 0; i < 32; i++) begin
      cycle();
      chk_rg($sformatf("init%0d", i), 1'b1, 5'(i), 32'h0);
      chk($sformatf("init%0d.init_done", i), 64'(bus.InitDone), 64'(i == 31));
    end
    cycle();
    chk_rg("init_end", 1'b0, 5'd0, 32'h0);
    chk("init_end.init_done", 64'(bus.InitDone), 64'd1);

    // Back-to-back conflicts alternate starting with ALU.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      #1;
      chk_rdy($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
      cycle();
      if ((k % 2) == 0) chk_rg($sformatf("rr%0d", k), 1'b1, 5'd1, 32'h11);
      else              chk_rg($sformatf("rr%0d", k), 1'b1, 5'd2, 32'h22);
    end

    // Lone ALU, lone MEM.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    chk_rdy("alu_only", 1'b1, 1'b0);
    cycle();
    chk_rg("alu_only", 1'b1, 5'd5, 32'hDEADBEEF);

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hCAFE);
    #1;
    chk_rdy("mem_only", 1'b0, 1'b1);
    cycle();
    chk_rg("mem_only", 1'b1, 5'd7, 32'hCAFE);

    // r0 write is accepted but suppressed.
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0);
    #1;
    chk_rdy("r0", 1'b1, 1'b0);
    cycle();
    chk_rg("r0", 1'b0, 5'd0, 32'h0);

    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk_rdy("idle", 1'b0, 1'b0);
    cycle();
    chk_rg("idle", 1'b0, 5'd0, 32'h0);

    // Last transfer was the (suppressed) ALU r0 write, so MEM wins now.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    #1;
    chk_rdy("rr_after_alu", 1'b0, 1'b1);
    cycle();
    chk_rg("rr_after_alu", 1'b1, 5'd2, 32'h22);

    // Reset pulse with MEM pending: in-flight write dropped at once.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    #1;
    chk_rdy("pre_rst", 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk_rg("mid_rst", 1'b0, 5'd0, 32'h0);
    chk_rdy("mid_rst", 1'b0, 1'b0);
    chk("mid_rst.init_done", 64'(bus.InitDone), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // INIT restarts from Dst=0; ALU request raised at cycle 10 waits for RUN.
    for (int i = 0; i < 32; i++) begin
      cycle();
      chk_rg($sformatf("reinit%0d", i), 1'b1, 5'(i), 32'h0);
      if (i == 10) drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
      #1;
      chk_rdy($sformatf("reinit%0d", i), i == 31 && i >= 10, 1'b0);
    end
    cycle();
    chk_rg("late_req", 1'b1, 5'd3, 32'h33);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk_rg("late_req_done", 1'b0, 5'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
